id_ex: RTL and testbench
========================

Name: id_ex

Overview:
Pipeline register between the decode stage and the combinational execute stage. It presents a stable operand/opcode bundle to execute, using a valid/ready handshake with a 2-entry skid buffer. It forwards the execute-stage write-back result into captured or waiting operands, which closes the back-to-back RAW hazard. Flush inserts bubbles.

Parameters:
NOP_INS, 32'h00000013, instruction word driven on `ins` for bubbles (ADDI x0,x0,0).
OH_W, 5, width of the one-hot/opcode select `oh`.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
valid_id  input  1  decode presents a valid instruction
ready_id  output  1  stage can accept (skid entry empty)
ins_id  input  32  instruction word
ins_add_id  input  32  instruction address
op1_id  input  32  rs1 value read from register file
op2_id  input  32  rs2 value or immediate
rs1_addr_id  input  5  rs1 index
rs2_addr_id  input  5  rs2 index
use_rs1_id  input  1  op1 comes from rs1
use_rs2_id  input  1  op2 comes from rs2 (0 for immediates, e.g. ADDI)
rd_addr_id  input  5  destination index
rd_wen_id  input  1  destination write enable
oh_id  input  OH_W  operation select (1 ADDI, 2 ADD, 3 SUB, 0 none)
flush  input  1  discard all held instructions
ex_ready  input  1  execute/write-back accepts current output
fwd_wen  input  1  execute write-back valid this cycle
fwd_addr  input  5  execute write-back index
fwd_data  input  32  execute write-back data
valid_ex  output  1  output bundle valid
ins  output  32  to execute
ins_add2ex  output  32  to execute
op1  output  32  to execute
op2  output  32  to execute
rd_addr2ex  output  5  to execute
rd_wen  output  1  to execute; forced 0 when `valid_ex`=0
oh  output  OH_W  to execute; forced 0 when `valid_ex`=0

Behaviour:
- Storage: the main entry M drives the outputs. The skid entry S holds one extra instruction.
- Reset (rst=1 at edge): M and S are invalid. Outputs read `valid_ex`=0, `ins`=NOP_INS, `ins_add2ex`=0, `op1`=`op2`=0, `rd_addr2ex`=0, `rd_wen`=0, `oh`=0. `ready_id`=1 after reset.
- Reset has priority over flush and over all handshakes, including a reset asserted mid-transfer.
- `ready_id` = !S.valid. It is a registered signal and has no combinational path from `ex_ready`.
- Accept: an incoming instruction is accepted when `valid_id` && `ready_id`.
- Retire: M retires when `valid_ex` && `ex_ready`.
- Latency: an accepted instruction appears at the outputs on the next cycle if M is empty or retiring.
- Next-state rules:
  - M retires or is empty, and S is valid: S moves to M. An accepted input goes to S.
  - M retires or is empty, and S is empty: the accepted input goes to M.
  - M is held and an input is accepted: the input goes to S.
  - Order is preserved.
- Invalid M drives the bubble values (same as reset values; `op1`/`op2` may hold, but `rd_wen` and `oh` must be 0).
- Forwarding:
  - Condition: `fwd_wen` && `fwd_addr`!=0 && use flag set && rs index == `fwd_addr`.
  - The affected operand is replaced with `fwd_data` on the incoming capture path.
  - The same check is applied every cycle to S's stored operands. S therefore keeps rs1/rs2 indices and use flags.
  - M's operands are never modified, because `fwd_*` is M's own result.
  - op1 and op2 are checked independently; both may forward in the same cycle.
- x0: never forwarded; the register-file value passes through unchanged.
- Flush (rst=0): M and S become invalid at the edge. The input in the same cycle is dropped, even if `valid_id`=1. `ready_id`=1 on the next cycle.
- Simultaneous events: flush with `ex_ready`=1 still lets the current M retire this cycle (downstream sees it); only the held state is discarded.
- No arithmetic is performed; all widths pass through unchanged.

Test Plan:
1. Reset, then present ADD (oh=2, op1=5, op2=7, rd=3, `valid_id`=1) with `ex_ready`=1 -> next cycle `valid_ex`=1, `oh`=2, `op1`=5, `op2`=7, `rd_addr2ex`=3, `rd_wen`=1. The following cycle with no input gives `valid_ex`=0, `oh`=0, `rd_wen`=0, `ins`=32'h00000013.
2. Stall: `ex_ready`=0 for 3 cycles while decode streams A, B, C -> A is held on the outputs and B fills S. `ready_id` drops and C waits. On `ex_ready`=1 the outputs show A, then B, then C with none lost or duplicated.
3. Forwarding on capture: `fwd_wen`=1, `fwd_addr`=4, `fwd_data`=0x64, incoming SUB rs1=4 (use_rs1=1, op1_id=0 stale), rs2=4 (use_rs2=1) -> next cycle `op1`=`op2`=0x64.
4. Immediate and x0 cases: ADDI with use_rs2=0, rs2 field=4, and a match on `fwd_addr`=4 -> `op2` keeps the immediate. An instruction with rs1=0 and `fwd_addr`=0 -> no forwarding.
5. Skid forwarding: B sits in S with rs1=6, and `fwd_wen`=1, `fwd_addr`=6, `fwd_data`=0xAA arrives while stalled -> when B reaches the outputs, `op1`=0xAA.
6. Flush/reset: with M and S full, assert `flush` alongside `valid_id`=1 -> next cycle `valid_ex`=0, `ready_id`=1, and the dropped input never appears. Repeat with `rst` asserted -> outputs return to their reset values.

Source files
------------

// File: rtl/id_ex.sv
// Decode-to-execute pipeline register: main entry M drives execute, skid entry S
// absorbs one extra instruction, and write-back results are forwarded into waiting operands.
module id_ex #(
    parameter logic [31:0] NOP_INS = 32'h00000013,
    parameter int          OH_W    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_id,
    output logic            ready_id,
    input  logic [31:0]     ins_id,
    input  logic [31:0]     ins_add_id,
    input  logic [31:0]     op1_id,
    input  logic [31:0]     op2_id,
    input  logic [4:0]      rs1_addr_id,
    input  logic [4:0]      rs2_addr_id,
    input  logic            use_rs1_id,
    input  logic            use_rs2_id,
    input  logic [4:0]      rd_addr_id,
    input  logic            rd_wen_id,
    input  logic [OH_W-1:0] oh_id,
    input  logic            flush,
    input  logic            ex_ready,
    input  logic            fwd_wen,
    input  logic [4:0]      fwd_addr,
    input  logic [31:0]     fwd_data,
    output logic            valid_ex,
    output logic [31:0]     ins,
    output logic [31:0]     ins_add2ex,
    output logic [31:0]     op1,
    output logic [31:0]     op2,
    output logic [4:0]      rd_addr2ex,
    output logic            rd_wen,
    output logic [OH_W-1:0] oh
);

    logic            m_valid;
    logic [31:0]     m_ins;
    logic [31:0]     m_add;
    logic [31:0]     m_op1;
    logic [31:0]     m_op2;
    logic [4:0]      m_rd;
    logic            m_wen;
    logic [OH_W-1:0] m_oh;

    logic            s_valid;
    logic [31:0]     s_ins;
    logic [31:0]     s_add;
    logic [31:0]     s_op1;
    logic [31:0]     s_op2;
    logic [4:0]      s_rs1;
    logic [4:0]      s_rs2;
    logic            s_use1;
    logic            s_use2;
    logic [4:0]      s_rd;
    logic            s_wen;
    logic [OH_W-1:0] s_oh;

    logic        fwd_live;
    logic [31:0] in_op1;
    logic [31:0] in_op2;
    logic [31:0] s_op1_f;
    logic [31:0] s_op2_f;
    logic        accept;
    logic        m_free;

    // x0 is never a forwarding target; immediates are protected by the use flags
    assign fwd_live = fwd_wen && (fwd_addr != 5'd0);
    assign in_op1   = (fwd_live && use_rs1_id && rs1_addr_id == fwd_addr) ? fwd_data : op1_id;
    assign in_op2   = (fwd_live && use_rs2_id && rs2_addr_id == fwd_addr) ? fwd_data : op2_id;
    assign s_op1_f  = (fwd_live && s_use1 && s_rs1 == fwd_addr) ? fwd_data : s_op1;
    assign s_op2_f  = (fwd_live && s_use2 && s_rs2 == fwd_addr) ? fwd_data : s_op2;

    assign ready_id = !s_valid;
    assign accept   = valid_id && !s_valid;
    assign m_free   = !m_valid || ex_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (m_free) begin
            if (s_valid) begin
                m_valid <= 1'b1;
                m_ins   <= s_ins;
                m_add   <= s_add;
                m_op1   <= s_op1_f;
                m_op2   <= s_op2_f;
                m_rd    <= s_rd;
                m_wen   <= s_wen;
                m_oh    <= s_oh;
                s_valid <= 1'b0;
            end else begin
                m_valid <= accept;
                if (accept) begin
                    m_ins <= ins_id;
                    m_add <= ins_add_id;
                    m_op1 <= in_op1;
                    m_op2 <= in_op2;
                    m_rd  <= rd_addr_id;
                    m_wen <= rd_wen_id;
                    m_oh  <= oh_id;
                end
            end
        end else if (accept) begin
            s_valid <= 1'b1;
            s_ins   <= ins_id;
            s_add   <= ins_add_id;
            s_op1   <= in_op1;
            s_op2   <= in_op2;
            s_rs1   <= rs1_addr_id;
            s_rs2   <= rs2_addr_id;
            s_use1  <= use_rs1_id;
            s_use2  <= use_rs2_id;
            s_rd    <= rd_addr_id;
            s_wen   <= rd_wen_id;
            s_oh    <= oh_id;
        end else begin
            s_op1 <= s_op1_f;
            s_op2 <= s_op2_f;
        end
    end

    // An empty M presents a harmless bubble so execute needs no extra qualification
    assign valid_ex   = m_valid;
    assign ins        = m_valid ? m_ins : NOP_INS;
    assign ins_add2ex = m_valid ? m_add : 32'd0;
    assign op1        = m_valid ? m_op1 : 32'd0;
    assign op2        = m_valid ? m_op2 : 32'd0;
    assign rd_addr2ex = m_valid ? m_rd : 5'd0;
    assign rd_wen     = m_valid && m_wen;
    assign oh         = m_valid ? m_oh : {OH_W{1'b0}};

endmodule

// File: tb/tb_id_ex.sv
// Self-checking bench for id_ex: directed vector table, hand-written stall/flush/reset
// sequences, and random traffic checked against a queue-based reference model.
module tb_id_ex;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_id;
    logic        ready_id;
    logic [31:0] ins_id;
    logic [31:0] ins_add_id;
    logic [31:0] op1_id;
    logic [31:0] op2_id;
    logic [4:0]  rs1_addr_id;
    logic [4:0]  rs2_addr_id;
    logic        use_rs1_id;
    logic        use_rs2_id;
    logic [4:0]  rd_addr_id;
    logic        rd_wen_id;
    logic [4:0]  oh_id;
    logic        flush;
    logic        ex_ready;
    logic        fwd_wen;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic        valid_ex;
    logic [31:0] ins_ex;
    logic [31:0] ins_add_ex;
    logic [31:0] op1_ex;
    logic [31:0] op2_ex;
    logic [4:0]  rd_addr_ex;
    logic        rd_wen_ex;
    logic [4:0]  oh_ex;

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    id_ex #(.NOP_INS(NOP), .OH_W(5)) dut (
        .clk(clk), .rst(rst),
        .valid_id(valid_id), .ready_id(ready_id),
        .ins_id(ins_id), .ins_add_id(ins_add_id),
        .op1_id(op1_id), .op2_id(op2_id),
        .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
        .rd_addr_id(rd_addr_id), .rd_wen_id(rd_wen_id), .oh_id(oh_id),
        .flush(flush), .ex_ready(ex_ready),
        .fwd_wen(fwd_wen), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .valid_ex(valid_ex), .ins(ins_ex), .ins_add2ex(ins_add_ex),
        .op1(op1_ex), .op2(op2_ex), .rd_addr2ex(rd_addr_ex),
        .rd_wen(rd_wen_ex), .oh(oh_ex)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] add;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use1;
        logic        use2;
        logic [4:0]  rd;
        logic        wen;
        logic [4:0]  oh;
    } instr_t;

    typedef struct {
        instr_t      in;
        logic        fw;
        logic [4:0]  fa;
        logic [31:0] fd;
        logic [31:0] exp_op1;
        logic [31:0] exp_op2;
    } vec_t;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input instr_t i, input logic v);
        valid_id    = v;
        ins_id      = i.ins;
        ins_add_id  = i.add;
        op1_id      = i.op1;
        op2_id      = i.op2;
        rs1_addr_id = i.rs1;
        rs2_addr_id = i.rs2;
        use_rs1_id  = i.use1;
        use_rs2_id  = i.use2;
        rd_addr_id  = i.rd;
        rd_wen_id   = i.wen;
        oh_id       = i.oh;
    endtask

    task automatic setFwd(input logic w, input logic [4:0] a, input logic [31:0] d);
        fwd_wen  = w;
        fwd_addr = a;
        fwd_data = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic instr_t mk(input logic [31:0] add, input logic [4:0] rs1, input logic use1,
                                  input logic [31:0] o1, input logic [4:0] rs2, input logic use2,
                                  input logic [31:0] o2, input logic [4:0] rd, input logic [4:0] oh);
        instr_t r;
        r.ins  = 32'h0000_0033 | (add << 12);
        r.add  = add;
        r.op1  = o1;
        r.op2  = o2;
        r.rs1  = rs1;
        r.rs2  = rs2;
        r.use1 = use1;
        r.use2 = use2;
        r.rd   = rd;
        r.wen  = (rd != 5'd0);
        r.oh   = oh;
        return r;
    endfunction

    // Reference model: in-order queue of held instructions, head is what execute sees
    instr_t mq[$];
    instr_t model_in;
    bit     model_acc;

    function automatic instr_t fwdApply(input instr_t e, input logic w, input logic [4:0] a,
                                        input logic [31:0] d);
        instr_t r = e;
        if (w && a != 5'd0 && e.use1 && e.rs1 == a) r.op1 = d;
        if (w && a != 5'd0 && e.use2 && e.rs2 == a) r.op2 = d;
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst || flush) begin
            mq.delete();
        end else begin
            model_acc     = valid_id && (mq.size() < 2);
            model_in.ins  = ins_id;
            model_in.add  = ins_add_id;
            model_in.op1  = op1_id;
            model_in.op2  = op2_id;
            model_in.rs1  = rs1_addr_id;
            model_in.rs2  = rs2_addr_id;
            model_in.use1 = use_rs1_id;
            model_in.use2 = use_rs2_id;
            model_in.rd   = rd_addr_id;
            model_in.wen  = rd_wen_id;
            model_in.oh   = oh_id;
            for (int i = 1; i < mq.size(); i++) mq[i] = fwdApply(mq[i], fwd_wen, fwd_addr, fwd_data);
            if (mq.size() > 0 && ex_ready) void'(mq.pop_front());
            if (model_acc) mq.push_back(fwdApply(model_in, fwd_wen, fwd_addr, fwd_data));
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            checkOutput("model_ready", {63'd0, ready_id}, {63'd0, mq.size() < 2});
            checkOutput("model_valid", {63'd0, valid_ex}, {63'd0, mq.size() > 0});
            if (mq.size() > 0) begin
                checkOutput("model_ins", {32'd0, ins_ex}, {32'd0, mq[0].ins});
                checkOutput("model_add", {32'd0, ins_add_ex}, {32'd0, mq[0].add});
                checkOutput("model_ops", {op1_ex, op2_ex}, {mq[0].op1, mq[0].op2});
                checkOutput("model_ctl", {52'd0, rd_addr_ex, rd_wen_ex, oh_ex},
                            {52'd0, mq[0].rd, mq[0].wen, mq[0].oh});
            end else begin
                checkOutput("model_bubble_ins", {32'd0, ins_ex}, {32'd0, NOP});
                checkOutput("model_bubble_ctl", {52'd0, rd_addr_ex, rd_wen_ex, oh_ex}, 64'd0);
            end
        end
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_valid"}, {63'd0, valid_ex}, 64'd0);
        checkOutput({tag, "_ins"}, {32'd0, ins_ex}, {32'd0, NOP});
        checkOutput({tag, "_add"}, {32'd0, ins_add_ex}, 64'd0);
        checkOutput({tag, "_ops"}, {op1_ex, op2_ex}, 64'd0);
        checkOutput({tag, "_ctl"}, {52'd0, rd_addr_ex, rd_wen_ex, oh_ex}, 64'd0);
        checkOutput({tag, "_ready"}, {63'd0, ready_id}, 64'd1);
    endtask

    vec_t   vecs[6];
    instr_t idle;
    instr_t a_i;
    instr_t b_i;
    instr_t c_i;
    instr_t d_i;

    initial begin
        idle = mk(32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 5'd0);
        rst = 1'b1;
        flush = 1'b0;
        ex_ready = 1'b1;
        applyStimulus(idle, 1'b0);
        setFwd(1'b0, 5'd0, 32'h0);

        vecs[0] = '{mk(32'h100, 5'd1, 1'b1, 32'd5, 5'd2, 1'b1, 32'd7, 5'd3, 5'd2),
                    1'b0, 5'd0, 32'h0, 32'd5, 32'd7};
        vecs[1] = '{mk(32'h104, 5'd4, 1'b1, 32'd0, 5'd4, 1'b1, 32'd0, 5'd5, 5'd3),
                    1'b1, 5'd4, 32'h64, 32'h64, 32'h64};
        vecs[2] = '{mk(32'h108, 5'd1, 1'b1, 32'd9, 5'd4, 1'b0, 32'h10, 5'd6, 5'd1),
                    1'b1, 5'd4, 32'h55, 32'd9, 32'h10};
        vecs[3] = '{mk(32'h10c, 5'd0, 1'b1, 32'h33, 5'd0, 1'b1, 32'h44, 5'd7, 5'd2),
                    1'b1, 5'd0, 32'h99, 32'h33, 32'h44};
        vecs[4] = '{mk(32'h110, 5'd7, 1'b1, 32'h21, 5'd2, 1'b1, 32'h22, 5'd8, 5'd2),
                    1'b0, 5'd7, 32'h77, 32'h21, 32'h22};
        vecs[5] = '{mk(32'h114, 5'd8, 1'b1, 32'h31, 5'd9, 1'b1, 32'h32, 5'd9, 5'd3),
                    1'b1, 5'd9, 32'hBEEF, 32'h31, 32'hBEEF};

        tick;
        tick;
        model_on = 1'b1;
        checkResetValues("reset");
        rst = 1'b0;
        tick;

        // Single-instruction vectors: capture path, forwarding, immediates, x0
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].in, 1'b1);
            setFwd(vecs[i].fw, vecs[i].fa, vecs[i].fd);
            tick;
            applyStimulus(idle, 1'b0);
            setFwd(1'b0, 5'd0, 32'h0);
            checkOutput($sformatf("vec%0d_valid", i), {63'd0, valid_ex}, 64'd1);
            checkOutput($sformatf("vec%0d_ops", i), {op1_ex, op2_ex}, {vecs[i].exp_op1, vecs[i].exp_op2});
            checkOutput($sformatf("vec%0d_ctl", i), {52'd0, rd_addr_ex, rd_wen_ex, oh_ex},
                        {52'd0, vecs[i].in.rd, 1'b1, vecs[i].in.oh});
            checkOutput($sformatf("vec%0d_ins", i), {32'd0, ins_ex}, {32'd0, vecs[i].in.ins});
            tick;
            checkOutput($sformatf("vec%0d_bubble", i), {31'd0, valid_ex, ins_ex},
                        {31'd0, 1'b0, NOP});
            checkOutput($sformatf("vec%0d_bubble_ctl", i), {58'd0, rd_wen_ex, oh_ex}, 64'd0);
        end

        // Stall with A, B, C streaming; B is forwarded while parked in the skid entry
        a_i = mk(32'h200, 5'd1, 1'b1, 32'hA1, 5'd2, 1'b1, 32'hA2, 5'd10, 5'd2);
        b_i = mk(32'h204, 5'd6, 1'b1, 32'h0, 5'd2, 1'b1, 32'hB2, 5'd11, 5'd3);
        c_i = mk(32'h208, 5'd1, 1'b1, 32'hC1, 5'd2, 1'b0, 32'hC2, 5'd12, 5'd1);
        ex_ready = 1'b0;
        applyStimulus(a_i, 1'b1);
        tick;
        checkOutput("stall_a_out", {32'd0, ins_add_ex}, {32'd0, a_i.add});
        checkOutput("stall_ready1", {63'd0, ready_id}, 64'd1);
        applyStimulus(b_i, 1'b1);
        tick;
        checkOutput("stall_a_held", {32'd0, ins_add_ex}, {32'd0, a_i.add});
        checkOutput("stall_ready_drop", {63'd0, ready_id}, 64'd0);
        applyStimulus(c_i, 1'b1);
        setFwd(1'b1, 5'd6, 32'hAA);
        tick;
        checkOutput("stall_a_still", {32'd0, ins_add_ex}, {32'd0, a_i.add});
        checkOutput("stall_c_waits", {63'd0, ready_id}, 64'd0);
        setFwd(1'b0, 5'd0, 32'h0);
        ex_ready = 1'b1;
        tick;
        checkOutput("drain_b", {32'd0, ins_add_ex}, {32'd0, b_i.add});
        checkOutput("skid_fwd_op1", {32'd0, op1_ex}, {32'd0, 32'hAA});
        checkOutput("drain_ready", {63'd0, ready_id}, 64'd1);
        tick;
        applyStimulus(idle, 1'b0);
        checkOutput("drain_c", {32'd0, ins_add_ex}, {32'd0, c_i.add});
        tick;
        checkOutput("drain_empty", {63'd0, valid_ex}, 64'd0);

        // Flush with M and S full: current M retires, held state and input are discarded
        d_i = mk(32'h300, 5'd1, 1'b1, 32'hD1, 5'd2, 1'b1, 32'hD2, 5'd13, 5'd2);
        ex_ready = 1'b0;
        applyStimulus(a_i, 1'b1);
        tick;
        applyStimulus(b_i, 1'b1);
        tick;
        applyStimulus(d_i, 1'b1);
        flush = 1'b1;
        ex_ready = 1'b1;
        checkOutput("flush_m_visible", {31'd0, valid_ex, ins_add_ex}, {31'd0, 1'b1, a_i.add});
        tick;
        flush = 1'b0;
        applyStimulus(idle, 1'b0);
        checkOutput("flush_full_valid", {63'd0, valid_ex}, 64'd0);
        checkOutput("flush_full_ready", {63'd0, ready_id}, 64'd1);
        tick;
        checkOutput("flush_full_after", {63'd0, valid_ex}, 64'd0);

        // Flush with only M held: input would otherwise be accepted into S
        ex_ready = 1'b0;
        applyStimulus(a_i, 1'b1);
        tick;
        applyStimulus(d_i, 1'b1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        applyStimulus(idle, 1'b0);
        ex_ready = 1'b1;
        checkOutput("flush_m_valid", {63'd0, valid_ex}, 64'd0);
        tick;
        checkOutput("flush_m_dropped", {63'd0, valid_ex}, 64'd0);

        // Reset mid-transfer beats flush and handshakes
        ex_ready = 1'b0;
        applyStimulus(a_i, 1'b1);
        tick;
        applyStimulus(b_i, 1'b1);
        tick;
        applyStimulus(d_i, 1'b1);
        rst = 1'b1;
        flush = 1'b1;
        ex_ready = 1'b1;
        tick;
        checkResetValues("midreset");
        rst = 1'b0;
        flush = 1'b0;
        applyStimulus(idle, 1'b0);
        tick;
        checkOutput("midreset_after", {63'd0, valid_ex}, 64'd0);

        // Random traffic; small register range makes forwarding hits frequent
        for (int n = 0; n < 600; n++) begin
            instr_t r;
            r = mk($urandom, 5'($urandom_range(0, 3)), 1'($urandom), $urandom,
                   5'($urandom_range(0, 3)), 1'($urandom), $urandom,
                   5'($urandom_range(0, 31)), 5'($urandom_range(0, 3)));
            r.wen = 1'($urandom);
            applyStimulus(r, $urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 79) == 0);
            setFwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            tick;
        end
        rst = 1'b0;
        flush = 1'b0;
        applyStimulus(idle, 1'b0);
        tick;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
